// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-path constants and the queue entry type
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - DEPTH x 64-bit entry storage, synchronous write, asynchronous read
module fetch_queue_mem
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [2*XLEN-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [2*XLEN-1:0] rd_data
);

  // Contents are meaningless until written, so the array carries no reset.
  logic [2*XLEN-1:0] mem_q [DEPTH];

  // Capture the incoming entry at the write pointer.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc, instr} buffer between fetch and decode with redirect flush
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic            out_valid,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_pc_plus4,
  output logic [31:0]     out_instr,
  input  logic            out_ready,
  input  logic            flush,
  output logic [AW:0]     count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // in_ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  // Head is presented straight from storage; decode sees a NOP whenever the queue is empty.
  assign out_pc       = head.pc;
  assign out_pc_plus4 = head.pc + PC_STEP;
  assign out_instr    = out_valid ? head.instr : INSTR_NOP;

  // Next pointer/occupancy: a redirect wins over any handshake and empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset empties the queue immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
  import mips_pkg::*;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus4;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_n;
  fetch_entry_t sb[$];
  fetch_entry_t head_e;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .out_instr    (out_instr),
    .out_ready    (out_ready),
    .flush        (flush),
    .count        (count)
  );

  always #5 clock = ~clock;

  // Scoreboard: at each falling edge check outputs against the model, then apply this cycle's handshake.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      exp_n = sb.size();
      n_cmp++;
      if (count !== exp_n[AW:0]) begin
        n_err++; $display("FAIL mon_count: got %0d expected %0d", count, exp_n);
      end
      n_cmp++;
      if (in_ready !== (exp_n < DEPTH)) begin
        n_err++; $display("FAIL mon_in_ready: got %0b expected %0b", in_ready, exp_n < DEPTH);
      end
      n_cmp++;
      if (out_valid !== (exp_n != 0)) begin
        n_err++; $display("FAIL mon_out_valid: got %0b expected %0b", out_valid, exp_n != 0);
      end
      if (exp_n != 0) begin
        head_e = sb[0];
        n_cmp++;
        if (out_pc !== head_e.pc) begin
          n_err++; $display("FAIL mon_out_pc: got %08h expected %08h", out_pc, head_e.pc);
        end
        n_cmp++;
        if (out_instr !== head_e.instr) begin
          n_err++; $display("FAIL mon_out_instr: got %08h expected %08h", out_instr, head_e.instr);
        end
        n_cmp++;
        if (out_pc_plus4 !== head_e.pc + 32'd4) begin
          n_err++; $display("FAIL mon_pc_plus4: got %08h expected %08h", out_pc_plus4, head_e.pc + 32'd4);
        end
      end else begin
        n_cmp++;
        if (out_instr !== 32'h0) begin
          n_err++; $display("FAIL mon_nop: got %08h expected 00000000", out_instr);
        end
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (exp_n != 0 && out_ready) void'(sb.pop_front());
        if (in_valid && exp_n < DEPTH) sb.push_back('{pc: in_pc, instr: in_instr});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    #2;
    n_cmp++;
    if ({count, out_valid, out_instr, in_ready} !== {2'd0, 1'b0, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL reset_state: got cnt=%0d v=%0b i=%08h r=%0b expected 0 0 0 1", count, out_valid, out_instr, in_ready);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({count, out_valid, out_instr, in_ready} !== {2'd0, 1'b0, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL reset_idle: got cnt=%0d v=%0b i=%08h r=%0b expected 0 0 0 1", count, out_valid, out_instr, in_ready);
    end
  endtask

  task automatic test_fill_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h0040_0000; in_instr = 32'h2008_0005;
    tick();
    in_pc = 32'h0040_0004; in_instr = 32'h2009_0003;
    tick();
    n_cmp++;
    if ({count, in_ready} !== {2'd2, 1'b0}) begin
      n_err++; $display("FAIL fill_full: got cnt=%0d r=%0b expected 2 0", count, in_ready);
    end
    n_cmp++;
    if ({out_pc, out_pc_plus4} !== {32'h0040_0000, 32'h0040_0004}) begin
      n_err++; $display("FAIL fill_head: got %08h/%08h expected 00400000/00400004", out_pc, out_pc_plus4);
    end
    in_pc = 32'h0040_0008; in_instr = 32'hdead_beef;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({count, out_pc, out_instr} !== {2'd2, 32'h0040_0000, 32'h2008_0005}) begin
      n_err++; $display("FAIL fill_ignored: got cnt=%0d pc=%08h i=%08h expected 2 00400000 20080005", count, out_pc, out_instr);
    end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_instr !== 32'h2008_0005) begin
      n_err++; $display("FAIL drain_first: got %08h expected 20080005", out_instr);
    end
    tick();
    n_cmp++;
    if (out_instr !== 32'h2009_0003) begin
      n_err++; $display("FAIL drain_second: got %08h expected 20090003", out_instr);
    end
    tick();
    n_cmp++;
    if ({out_valid, count, out_instr} !== {1'b0, 2'd0, 32'h0}) begin
      n_err++; $display("FAIL drain_empty: got v=%0b cnt=%0d i=%08h expected 0 0 0", out_valid, count, out_instr);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pc = 32'h0040_0000 + 32'(4 * i);
      in_pc = pc; in_instr = 32'h1000_0000 | 32'(i);
      tick();
      n_cmp++;
      if ({count, out_pc} !== {2'd1, pc}) begin
        n_err++; $display("FAIL stream_%0d: got cnt=%0d pc=%08h expected 1 %08h", i, count, out_pc, pc);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (count !== 2'd0) begin
      n_err++; $display("FAIL stream_drain: got %0d expected 0", count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 32'h0040_0200; in_instr = 32'h1111_1111; tick();
    in_pc = 32'h0040_0204; in_instr = 32'h2222_2222; tick();
    n_cmp++;
    if (count !== 2'd2) begin
      n_err++; $display("FAIL flush_setup: got %0d expected 2", count);
    end
    flush = 1'b1; out_ready = 1'b1; in_pc = 32'h0040_0010; in_instr = 32'h3333_3333;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({count, out_valid, in_ready} !== {2'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL flush_full: got cnt=%0d v=%0b r=%0b expected 0 0 1", count, out_valid, in_ready);
    end
    // One entry held so the flushed input would otherwise have been accepted.
    in_valid = 1'b1; in_pc = 32'h0040_0300; in_instr = 32'h4444_4444; tick();
    flush = 1'b1; out_ready = 1'b1; in_pc = 32'h0040_0010; in_instr = 32'h3333_3333;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready);
    end
    tick();
    flush = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({count, out_valid} !== {2'd0, 1'b0}) begin
      n_err++; $display("FAIL flush_part: got cnt=%0d v=%0b expected 0 0", count, out_valid);
    end
    in_pc = 32'h0040_0100; in_instr = 32'h5555_5555; tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({count, out_pc, out_instr} !== {2'd1, 32'h0040_0100, 32'h5555_5555}) begin
      n_err++; $display("FAIL flush_redirect: got cnt=%0d pc=%08h i=%08h expected 1 00400100 55555555", count, out_pc, out_instr);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 32'h0040_0400; in_instr = 32'h6666_6666; tick();
    in_pc = 32'h0040_0404; in_instr = 32'h7777_7777; tick();
    in_valid = 1'b0;
    n_cmp++;
    if (count !== 2'd2) begin
      n_err++; $display("FAIL areset_setup: got %0d expected 2", count);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, count, in_ready, out_instr} !== {1'b0, 2'd0, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL areset_immediate: got v=%0b cnt=%0d r=%0b i=%08h expected 0 0 1 0", out_valid, count, in_ready, out_instr);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, count} !== {1'b0, 2'd0}) begin
      n_err++; $display("FAIL areset_after: got v=%0b cnt=%0d expected 0 0", out_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_drain();
    test_streaming();
    test_flush();
    test_async_reset();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
